axi_rd_arbiter: RTL

//  Round-robin arbiter that shares one axi_rd-style read helper between NUM_REQ requesters.
//  - Each requester sees the same enable/status handshake the helper itself offers.
//  - Sits between the requesters (ADC/UART readers) and the single axi_rd instance on the F2H AXI port.
//  - Issues the granted request, returns data and status to that requester, then rotates priority.

---
 rtl/axi_rd_arbiter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/axi_rd_arbiter.sv
// ---------------------------------------------------------------------------
// axi_rd_arbiter
//   Round-robin arbiter sharing one axi_rd read helper between NUM_REQ
//   requesters. Each requester sees the helper's own enable/status handshake.
//
// Handshake (identical on both sides of the arbiter):
//   A requester raises enable and holds it. Its status reads 0 ready,
//   1 wait, 2 ok, 3 error. Once status reaches 2/3 the result (req_data)
//   is valid and held until the requester drops enable. Status then returns
//   to 0, and the requester may only request again after that. The arbiter
//   drives rd_enable toward the helper with exactly the same rules.
//
// Ports
//   clock, reset              rising-edge clock, async active-high reset
//   req_enable[i]             requester i enable
//   req_addr/len/size         per-requester request fields, slice i
//   req_status[2i+:2]         requester i status
//   req_data                  captured read data of the last completed owner
//   grant                     one-hot owner, 0 when no transaction is held
//   rd_enable/id/addr/len/size  registered request toward the helper
//   rd_status, rd_data        helper response
//   dbg_state                 current FSM state
// ---------------------------------------------------------------------------
module axi_rd_arbiter #(
  parameter int NUM_REQ              = 4,
  parameter int AXI_RD_ID_WIDTH      = 8,
  parameter int AXI_RD_ADDR_WIDTH    = 32,
  parameter int AXI_RD_BUS_WIDTH     = 32,
  parameter int AXI_RD_MAX_BURST_LEN = 1
) (
  input  logic                                             clock,
  input  logic                                             reset,
  input  logic [NUM_REQ-1:0]                               req_enable,
  input  logic [NUM_REQ*AXI_RD_ADDR_WIDTH-1:0]             req_addr,
  input  logic [NUM_REQ*4-1:0]                             req_burst_len,
  input  logic [NUM_REQ*3-1:0]                             req_burst_size,
  output logic [NUM_REQ*2-1:0]                             req_status,
  output logic [AXI_RD_MAX_BURST_LEN*AXI_RD_BUS_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]                               grant,
  output logic                                             rd_enable,
  output logic [AXI_RD_ID_WIDTH-1:0]                       rd_id,
  output logic [AXI_RD_ADDR_WIDTH-1:0]                     rd_addr,
  output logic [3:0]                                       rd_burst_len,
  output logic [2:0]                                       rd_burst_size,
  input  logic [1:0]                                       rd_status,
  input  logic [AXI_RD_MAX_BURST_LEN*AXI_RD_BUS_WIDTH-1:0] rd_data,
  output logic [2:0]                                       dbg_state
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT    = 3'd2,
    DONE    = 3'd3,
    RELEASE = 3'd4
  } state_t;

  state_t          state, state_next;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   owner;
  logic [NUM_REQ-1:0] pending;
  logic            pick_valid;
  logic [IW-1:0]   pick_idx;
  logic            take_grant, done_hit, release_hit;

  // (base + k) mod NUM_REQ, for k in 0..NUM_REQ
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return s[IW-1:0];
  endfunction

  // Queued requesters sit at status 1 and stay eligible; a requester whose
  // status is still 2/3 has not yet completed its release handshake.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      pending[i] = req_enable[i] & ~req_status[2*i+1];
    end
  end

  // First pending requester at or after the priority pointer, wrapping.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!pick_valid && pending[wrap_add(ptr, k)]) begin
        pick_valid = 1'b1;
        pick_idx   = wrap_add(ptr, k);
      end
    end
  end

  assign take_grant  = (state == IDLE) && pick_valid;
  assign done_hit    = (state == WAIT) && rd_status[1];
  assign release_hit = (state == DONE) && !req_enable[owner] && (rd_status == 2'd0);
  assign dbg_state   = state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pick_valid) state_next = ISSUE;
      ISSUE:   if (rd_status == 2'd1) state_next = WAIT;
      WAIT:    if (rd_status[1]) state_next = DONE;
      DONE:    if (!req_enable[owner] && (rd_status == 2'd0)) state_next = RELEASE;
      RELEASE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      grant         <= '0;
      owner         <= '0;
      ptr           <= '0;
      rd_enable     <= 1'b0;
      rd_id         <= '0;
      rd_addr       <= '0;
      rd_burst_len  <= '0;
      rd_burst_size <= '0;
      req_status    <= '0;
      req_data      <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i]) begin
          // Owner holds "wait" even if it drops enable: the burst cannot be
          // aborted, so an abandoned result is dropped and status goes 1->0.
          if (done_hit)
            req_status[2*i +: 2] <= req_enable[i] ? rd_status : 2'd0;
          else if (release_hit)
            req_status[2*i +: 2] <= 2'd0;
        end else begin
          req_status[2*i +: 2] <= {1'b0, req_enable[i]};
        end
      end

      if (take_grant) begin
        grant         <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
        owner         <= pick_idx;
        rd_id         <= AXI_RD_ID_WIDTH'(pick_idx);
        rd_addr       <= req_addr[pick_idx*AXI_RD_ADDR_WIDTH +: AXI_RD_ADDR_WIDTH];
        rd_burst_len  <= req_burst_len[pick_idx*4 +: 4];
        rd_burst_size <= req_burst_size[pick_idx*3 +: 3];
        rd_enable     <= 1'b1;
      end

      if (done_hit) begin
        rd_enable <= 1'b0;
        if (req_enable[owner]) req_data <= rd_data;
      end

      if (release_hit) grant <= '0;

      // Rotating here, one cycle after the grant drops, also guarantees the
      // helper has seen enable low before the next issue.
      if (state == RELEASE) ptr <= wrap_add(owner, 1);
    end
  end

endmodule
